// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external memory bus between the PSRAM controller
// (port 0) and the PCM flash controller (port 1). Whole transactions are granted
// through req/gnt, ties go round-robin, and a programmable turnaround gap with all
// pins idle separates consecutive grants. A sticky flag reports over-long grants.
module mem_bus_arbiter #(
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_MAX    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        oe0_n,
  input  logic        we0_n,
  input  logic [22:0] addr0,
  input  logic [15:0] dout0,
  input  logic        ce0_n,
  output logic        gnt0,
  input  logic        req1,
  input  logic        oe1_n,
  input  logic        we1_n,
  input  logic [22:0] addr1,
  input  logic [15:0] dout1,
  input  logic        ce1_n,
  output logic        gnt1,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_dout,
  output logic        ram_ce_n,
  output logic        pcm_ce_n,
  output logic        err_hold
);

  // Hold counter must reach HOLD_MAX+1 (its saturation value).
  localparam int            HW        = $clog2(HOLD_MAX + 2);
  localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX + 1);
  localparam logic          HOLD_EN   = (HOLD_MAX != 0);
  localparam logic          HAS_TURN  = (TURN_CYCLES != 0);
  localparam logic [3:0]    TURN_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;     // 1: port 1 was granted most recently
  logic [3:0]    turn_q, turn_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_inc;
  logic          err_q, err_d;
  logic          in_gnt;

  // Grants are decoded straight from the state flops, so they are registered.
  assign gnt0     = (state_q == S_GNT0);
  assign gnt1     = (state_q == S_GNT1);
  assign err_hold = err_q;
  assign in_gnt   = (state_q == S_GNT0) || (state_q == S_GNT1);

  // Next-state, round-robin tie-break and turnaround counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    turn_d  = turn_q;
    case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
          if (last_q) begin
            state_d = S_GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = S_GNT1;
            last_d  = 1'b1;
          end
        end else if (req0) begin
          state_d = S_GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = S_GNT1;
          last_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GNT0, S_GNT1: begin
        if ((state_q == S_GNT0) ? !req0 : !req1) begin
          if (HAS_TURN) begin
            state_d = S_TURN;
            turn_d  = TURN_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_TURN: begin
        if (turn_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant-length watchdog: count completed grant cycles, flag once above HOLD_MAX.
  always_comb begin
    hold_inc = (hold_q == HOLD_SAT) ? HOLD_SAT : hold_q + {{(HW-1){1'b0}}, 1'b1};
    if (in_gnt && (state_d == state_q)) begin
      hold_d = hold_inc;
    end else begin
      hold_d = {HW{1'b0}};
    end
    if (in_gnt && HOLD_EN && (hold_inc > HOLD_LIM)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Arbiter state registers; reset returns to IDLE with port 0 winning the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      turn_q  <= 4'd0;
      hold_q  <= {HW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Shared pin mux: granted port drives the bus, otherwise everything is idle.
  // Keyed off state_q so an asynchronous reset idles the pins immediately.
  always_comb begin
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
    mem_addr = 23'd0;
    mem_dout = 16'd0;
    ram_ce_n = 1'b1;
    pcm_ce_n = 1'b1;
    case (state_q)
      S_GNT0: begin
        mem_oe_n = oe0_n;
        mem_we_n = we0_n;
        mem_addr = addr0;
        mem_dout = dout0;
        ram_ce_n = ce0_n;
      end
      S_GNT1: begin
        mem_oe_n = oe1_n;
        mem_we_n = we1_n;
        mem_addr = addr1;
        mem_dout = dout1;
        pcm_ce_n = ce1_n;
      end
      default: begin
        mem_oe_n = 1'b1;
      end
    endcase
  end

endmodule
